bcd_down_counter: RTL and testbench

- Multi-digit synchronous BCD down-counter. It is the count-down, borrow-producing counterpart of the team's decade up-counter with carry.
- Used for countdown timers and for preset dividers that are cascaded through borrow.
- Supports parallel BCD load, an optional auto-reload of the last loaded value, and a borrow-out that chains to the next stage's borrow-in.
- Flags non-BCD load data.

---
 rtl/bcd_down_counter_if.sv | 25 ++
 rtl/bcd_down_counter.sv | 88 ++++++++
 tb/tb_bcd_down_counter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_down_counter_if.sv
// Bus bundle for one BCD down-counter stage: load/count controls, the
// borrow chain and the status outputs.
interface bcd_down_counter_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic                  en;
  logic                  bin;
  logic [4*DIGITS-1:0]   data;
  logic [4*DIGITS-1:0]   q;
  logic                  bout;
  logic                  zero;
  logic                  done;
  logic                  err;

  modport master (
    output load, en, bin, data,
    input  q, bout, zero, done, err
  );

  modport slave (
    input  load, en, bin, data,
    output q, bout, zero, done, err
  );
endinterface

// File: rtl/bcd_down_counter.sv
// Multi-digit synchronous BCD down-counter with parallel load, optional
// auto-reload of the last good load value and a combinational borrow-out
// so that cascaded stages all step on the same edge.
module bcd_down_counter #(
  parameter int DIGITS      = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  bcd_down_counter_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0] count;
  logic [W-1:0] reload_val;
  logic [W-1:0] dec_val;
  logic [W-1:0] next_val;
  logic         data_ok;
  logic         q_is_zero;
  logic         dec_go;
  logic         borrow;
  logic         done_r;
  logic         err_r;

  assign q_is_zero = (count == '0);
  assign dec_go    = bus.en & bus.bin;

  // Borrow path stays purely combinational so a chain of stages ripples in one cycle.
  assign bus.q    = count;
  assign bus.zero = q_is_zero;
  assign bus.bout = q_is_zero & dec_go;
  assign bus.done = done_r;
  assign bus.err  = err_r;

  // A load is accepted only when every nibble is a legal decimal digit.
  always_comb begin
    data_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.data[4*i +: 4] > 4'd9) data_ok = 1'b0;
    end
  end

  // Digit-wise decrement: a digit steps only while every lower digit is 0, and 0 steps to 9.
  always_comb begin
    dec_val = count;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // At zero the wrap target is either all 9s (which dec_val already is) or the reload value.
  always_comb begin
    next_val = dec_val;
    if (q_is_zero && AUTO_RELOAD) next_val = reload_val;
  end

  // Count, reload, done and err registers: reset > load > decrement > hold.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count      <= '0;
      reload_val <= '0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else if (bus.load) begin
      if (data_ok) begin
        count      <= bus.data;
        reload_val <= bus.data;
        err_r      <= 1'b0;
      end else begin
        err_r <= 1'b1;
      end
      done_r <= 1'b0;
    end else if (dec_go) begin
      count  <= next_val;
      done_r <= !q_is_zero && (next_val == '0);
    end else begin
      done_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench: three counters (wrap, auto-reload, cascaded stage)
// compared every cycle against a decimal-arithmetic model, plus directed
// literal checks.
module tb_bcd_down_counter;
  localparam int D    = 4;
  localparam int MAXV = 9999;

  logic clk;
  logic clr_n;

  bcd_down_counter_if #(.DIGITS(D)) ifa ();
  bcd_down_counter_if #(.DIGITS(D)) ifr ();
  bcd_down_counter_if #(.DIGITS(D)) ifc ();

  // Stage c borrows from stage a.
  assign ifc.bin = ifa.bout;

  bcd_down_counter #(.DIGITS(D), .AUTO_RELOAD(1'b0)) dut_a (.clk(clk), .clr_n(clr_n), .bus(ifa));
  bcd_down_counter #(.DIGITS(D), .AUTO_RELOAD(1'b1)) dut_r (.clk(clk), .clr_n(clr_n), .bus(ifr));
  bcd_down_counter #(.DIGITS(D), .AUTO_RELOAD(1'b0)) dut_c (.clk(clk), .clr_n(clr_n), .bus(ifc));

  int compared   = 0;
  int mismatched = 0;
  bit armed      = 0;

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state, kept as plain decimal integers.
  int m_val [3];
  int m_rel [3];
  bit m_err [3];
  bit m_done[3];

  logic        ld   [3];
  logic [15:0] dat  [3];
  logic        en_m [3];
  logic        bin_m[3];
  bit          ar   [3];
  logic [15:0] q_act[3];
  logic        bout_act[3], zero_act[3], done_act[3], err_act[3];

  initial begin
    ar[0] = 0; ar[1] = 1; ar[2] = 0;
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] d);
    for (int i = 0; i < D; i++) if (d[4*i +: 4] > 4'd9) return 0;
    return 1;
  endfunction

  function automatic int bcd_val(input logic [15:0] d);
    int v;
    int scale;
    v = 0;
    scale = 1;
    for (int i = 0; i < D; i++) begin
      v = v + int'(d[4*i +: 4]) * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  // Gather per-instance inputs and outputs into arrays for the model and comparer.
  always_comb begin
    ld[0] = ifa.load; dat[0] = ifa.data; en_m[0] = ifa.en; bin_m[0] = ifa.bin;
    ld[1] = ifr.load; dat[1] = ifr.data; en_m[1] = ifr.en; bin_m[1] = ifr.bin;
    ld[2] = ifc.load; dat[2] = ifc.data; en_m[2] = ifc.en;
    bin_m[2] = (m_val[0] == 0) && en_m[0] && bin_m[0];
    q_act[0] = ifa.q; bout_act[0] = ifa.bout; zero_act[0] = ifa.zero; done_act[0] = ifa.done; err_act[0] = ifa.err;
    q_act[1] = ifr.q; bout_act[1] = ifr.bout; zero_act[1] = ifr.zero; done_act[1] = ifr.done; err_act[1] = ifr.err;
    q_act[2] = ifc.q; bout_act[2] = ifc.bout; zero_act[2] = ifc.zero; done_act[2] = ifc.done; err_act[2] = ifc.err;
  end

  // Model update on every rising edge.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!clr_n) begin
        m_val[k]  <= 0;
        m_rel[k]  <= 0;
        m_err[k]  <= 0;
        m_done[k] <= 0;
      end else if (ld[k]) begin
        if (bcd_ok(dat[k])) begin
          m_val[k] <= bcd_val(dat[k]);
          m_rel[k] <= bcd_val(dat[k]);
          m_err[k] <= 0;
        end else begin
          m_err[k] <= 1;
        end
        m_done[k] <= 0;
      end else if (en_m[k] && bin_m[k]) begin
        if (m_val[k] == 0) m_val[k] <= ar[k] ? m_rel[k] : MAXV;
        else               m_val[k] <= m_val[k] - 1;
        m_done[k] <= (m_val[k] == 1);
      end else begin
        m_done[k] <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("q[%0d]", k),    32'(q_act[k]),    32'(to_bcd(m_val[k])));
        checkOutput($sformatf("zero[%0d]", k), 32'(zero_act[k]), 32'(m_val[k] == 0));
        checkOutput($sformatf("bout[%0d]", k), 32'(bout_act[k]), 32'((m_val[k] == 0) && en_m[k] && bin_m[k]));
        checkOutput($sformatf("done[%0d]", k), 32'(done_act[k]), 32'(m_done[k]));
        checkOutput($sformatf("err[%0d]", k),  32'(err_act[k]),  32'(m_err[k]));
      end
    end
  end

  // Advance n cycles; inputs change 2 time units after the rising edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    clr_n = 1'b0;
    ifa.load = 1'b1; ifa.en = 1'b0; ifa.bin = 1'b1; ifa.data = 16'h1234;
    ifr.load = 1'b0; ifr.en = 1'b0; ifr.bin = 1'b1; ifr.data = 16'h0000;
    ifc.load = 1'b0; ifc.en = 1'b0; ifc.data = 16'h0000;

    // Reset dominates a simultaneous load.
    applyStimulus(2);
    armed = 1;
    checkOutput("reset_q", 32'(ifa.q), 32'h0000);
    checkOutput("reset_err", 32'(ifa.err), 32'h0);
    checkOutput("reset_done", 32'(ifa.done), 32'h0);
    clr_n = 1'b1; ifa.load = 1'b0;
    applyStimulus(1);
    checkOutput("hold_q", 32'(ifa.q), 32'h0000);

    // Borrow across digits, then run down to zero.
    ifa.load = 1'b1; ifa.data = 16'h1000;
    applyStimulus(1);
    ifa.load = 1'b0; ifa.en = 1'b1;
    applyStimulus(1);
    checkOutput("borrow_q", 32'(ifa.q), 32'h0999);
    applyStimulus(998);
    checkOutput("run_q_0001", 32'(ifa.q), 32'h0001);
    checkOutput("run_done_pre", 32'(ifa.done), 32'h0);
    applyStimulus(1);
    checkOutput("run_q_0000", 32'(ifa.q), 32'h0000);
    checkOutput("run_done", 32'(ifa.done), 32'h1);

    // Wrap to all 9s.
    #1;
    checkOutput("wrap_bout", 32'(ifa.bout), 32'h1);
    applyStimulus(1);
    checkOutput("wrap_q", 32'(ifa.q), 32'h9999);
    checkOutput("wrap_done", 32'(ifa.done), 32'h0);
    ifa.en = 1'b0;

    // Auto-reload instance.
    ifr.load = 1'b1; ifr.data = 16'h0003;
    applyStimulus(1);
    ifr.load = 1'b0; ifr.en = 1'b1;
    applyStimulus(3);
    checkOutput("ar_q_zero", 32'(ifr.q), 32'h0000);
    checkOutput("ar_done", 32'(ifr.done), 32'h1);
    #1;
    checkOutput("ar_bout", 32'(ifr.bout), 32'h1);
    applyStimulus(1);
    checkOutput("ar_reload_q", 32'(ifr.q), 32'h0003);
    checkOutput("ar_reload_done", 32'(ifr.done), 32'h0);
    ifr.load = 1'b1; ifr.data = 16'h0000;
    applyStimulus(1);
    ifr.load = 1'b0;
    #1;
    checkOutput("ar0_bout", 32'(ifr.bout), 32'h1);
    applyStimulus(2);
    checkOutput("ar0_q", 32'(ifr.q), 32'h0000);
    checkOutput("ar0_done", 32'(ifr.done), 32'h0);
    ifr.en = 1'b0;

    // Invalid load and priority.
    ifa.load = 1'b1; ifa.data = 16'h0500;
    applyStimulus(1);
    ifa.data = 16'h12A4;
    applyStimulus(1);
    checkOutput("bad_q", 32'(ifa.q), 32'h0500);
    checkOutput("bad_err", 32'(ifa.err), 32'h1);
    ifa.data = 16'h0042; ifa.en = 1'b1; ifa.bin = 1'b1;
    applyStimulus(1);
    checkOutput("ldpri_q", 32'(ifa.q), 32'h0042);
    checkOutput("ldpri_err", 32'(ifa.err), 32'h0);
    ifa.load = 1'b0; ifa.bin = 1'b0;
    applyStimulus(2);
    checkOutput("binlow_q", 32'(ifa.q), 32'h0042);

    // Cascade: stage a at 0000, stage c at 0005.
    ifa.load = 1'b1; ifa.data = 16'h0000; ifa.en = 1'b0; ifa.bin = 1'b1;
    ifc.load = 1'b1; ifc.data = 16'h0005;
    applyStimulus(1);
    ifa.load = 1'b0; ifc.load = 1'b0;
    ifa.en = 1'b1; ifc.en = 1'b1;
    #1;
    checkOutput("cas_bout", 32'(ifa.bout), 32'h1);
    applyStimulus(1);
    checkOutput("cas_q0", 32'(ifa.q), 32'h9999);
    checkOutput("cas_q1", 32'(ifc.q), 32'h0004);
    applyStimulus(1);
    checkOutput("cas_q1_hold", 32'(ifc.q), 32'h0004);
    clr_n = 1'b0;
    applyStimulus(1);
    checkOutput("cas_rst_q0", 32'(ifa.q), 32'h0000);
    checkOutput("cas_rst_q1", 32'(ifc.q), 32'h0000);
    clr_n = 1'b1; ifa.en = 1'b0; ifc.en = 1'b0;
    applyStimulus(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
